zbus_arbiter: RTL and testbench

Parametrised N:1 zbus arbiter and multiplexer connecting BN zbus masters to one zbus slave port. It is the successor to the fixed-priority zbus multiplexer. It adds a run-time selectable round-robin mode, an explicit grant/ID output for downstream routing, and an optional registered output stage with correct backpressure. It sits between master-side zbus ports and a shared slave or interconnect segment.

---
 rtl/zbus_pkg.sv | 16 +
 rtl/zbus_arbiter_if.sv | 28 ++
 rtl/zbus_arb_core.sv | 48 ++++
 rtl/zbus_arbiter.sv | 119 +++++++++++
 tb/tb_zbus_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/zbus_pkg.sv
// Shared zbus definitions: arbitration mode encodings, arbiter states and index-width helper.
package zbus_pkg;

  localparam logic ZBUS_MODE_FIXED = 1'b0;
  localparam logic ZBUS_MODE_RR    = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } zbus_state_e;

  function automatic int unsigned zbus_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/zbus_arbiter_if.sv
// zbus arbiter bundle: BN master-side ports (zi_*) and the shared slave-side port (zo_*).
interface zbus_arbiter_if #(
  parameter int unsigned BW  = 8,
  parameter int unsigned BN  = 4,
  parameter int unsigned BNL = zbus_pkg::zbus_idx_w(BN)
);
  logic [BN-1:0]    zi_vld;
  logic [BN-1:0]    zi_lck;
  logic [BW*BN-1:0] zi_bus;
  logic [BN-1:0]    zi_ack;
  logic             zo_vld;
  logic             zo_lck;
  logic [BW-1:0]    zo_bus;
  logic             zo_ack;
  logic [BNL-1:0]   zo_id;

  // Arbiter view: serves the upstream masters, drives the downstream slave.
  modport slave (
    input  zi_vld, zi_lck, zi_bus, zo_ack,
    output zi_ack, zo_vld, zo_lck, zo_bus, zo_id
  );

  // Environment view: masters plus the downstream slave.
  modport master (
    output zi_vld, zi_lck, zi_bus, zo_ack,
    input  zi_ack, zo_vld, zo_lck, zo_bus, zo_id
  );
endinterface

// File: rtl/zbus_arb_core.sv
// Combinational grant selection: fixed-priority list or round robin after rr_ptr.
module zbus_arb_core
  import zbus_pkg::*;
#(
  parameter int unsigned BN  = 4,
  parameter int unsigned BNL = zbus_idx_w(BN)
) (
  input  logic [BN-1:0]     req_i,
  input  logic [BNL*BN-1:0] prio_i,
  input  logic              mode_i,
  input  logic [BNL-1:0]    rr_ptr_i,
  output logic [BN-1:0]     gnt_o,
  output logic [BNL-1:0]    gnt_id_o
);
  logic [BNL-1:0] idx;
  int unsigned    pos;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    idx      = '0;
    pos      = 0;
    if (BN == 1) begin
      gnt_o = req_i;
    end else if (mode_i == ZBUS_MODE_RR) begin
      // Scan farthest-first so the requester nearest to rr_ptr+1 overwrites the rest
      for (int unsigned off = BN; off >= 1; off--) begin
        pos = (32'(rr_ptr_i) + off) % BN;
        if (req_i[BNL'(pos)]) begin
          gnt_o              = '0;
          gnt_o[BNL'(pos)]   = 1'b1;
          gnt_id_o           = BNL'(pos);
        end
      end
    end else begin
      // Lowest level scanned last, so duplicates resolve to the lowest level
      for (int unsigned k = BN; k >= 1; k--) begin
        idx = prio_i[(k-1)*BNL +: BNL];
        if ((32'(idx) < BN) && req_i[idx]) begin
          gnt_o      = '0;
          gnt_o[idx] = 1'b1;
          gnt_id_o   = idx;
        end
      end
    end
  end

endmodule

// File: rtl/zbus_arbiter.sv
// N:1 zbus arbiter/multiplexer with lock, fixed/round-robin mode and optional output register.
module zbus_arbiter
  import zbus_pkg::*;
#(
  parameter int unsigned BW  = 8,
  parameter int unsigned BN  = 4,
  parameter int unsigned BNL = zbus_idx_w(BN),
  parameter int unsigned REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_i,
  input  logic [BNL*BN-1:0] prio_i,
  zbus_arbiter_if.slave     zb
);
  zbus_state_e    state_q, state_d;
  logic [BNL-1:0] own_q, own_d;
  logic [BNL-1:0] rr_q, rr_d;
  logic [BN-1:0]  gnt, sel;
  logic [BNL-1:0] gnt_id, cur_id;
  logic           cur_any, cur_vld, cur_lck;
  logic [BW-1:0]  cur_bus;
  logic           acc, hs;

  zbus_arb_core #(.BN(BN), .BNL(BNL)) u_core (
    .req_i    (zb.zi_vld),
    .prio_i   (prio_i),
    .mode_i   (mode_i),
    .rr_ptr_i (rr_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  always_comb begin
    sel    = gnt;
    cur_id = gnt_id;
    if (state_q == ST_OWN) begin
      cur_id = own_q;
      for (int unsigned i = 0; i < BN; i++) sel[i] = (32'(own_q) == i);
    end
    cur_any = |sel;
    cur_vld = 1'b0;
    cur_lck = 1'b0;
    cur_bus = '0;
    for (int unsigned i = 0; i < BN; i++) begin
      if (sel[i]) begin
        cur_vld = zb.zi_vld[i];
        cur_lck = zb.zi_lck[i];
        cur_bus = zb.zi_bus[i*BW +: BW];
      end
    end
    hs      = cur_vld & acc;
    state_d = ST_IDLE;
    own_d   = own_q;
    rr_d    = rr_q;
    // Hold ownership across a pending beat or a locked (completed or idle) cycle
    if (cur_any && ((cur_vld && !hs) || cur_lck)) begin
      state_d = ST_OWN;
      own_d   = cur_id;
    end
    if (hs) rr_d = cur_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      own_q   <= '0;
      rr_q    <= BNL'(BN - 1);
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
    end
  end

  assign zb.zi_ack = sel & {BN{acc}};

  generate
    if (REG == 0) begin : g_comb
      assign acc       = zb.zo_ack;
      assign zb.zo_vld = cur_vld;
      assign zb.zo_lck = cur_lck;
      assign zb.zo_bus = cur_bus;
      assign zb.zo_id  = cur_any ? cur_id : '0;
    end else begin : g_reg
      logic           ovld_q, ovld_d;
      logic           olck_q, olck_d;
      logic [BW-1:0]  obus_q, obus_d;
      logic [BNL-1:0] oid_q, oid_d;

      // Stage accepts whenever it is empty or being drained this cycle
      assign acc    = ~ovld_q | zb.zo_ack;
      assign ovld_d = hs;
      assign olck_d = hs & cur_lck;
      assign obus_d = hs ? cur_bus : '0;
      assign oid_d  = hs ? cur_id : '0;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovld_q <= 1'b0;
          olck_q <= 1'b0;
          obus_q <= '0;
          oid_q  <= '0;
        end else if (acc) begin
          ovld_q <= ovld_d;
          olck_q <= olck_d;
          obus_q <= obus_d;
          oid_q  <= oid_d;
        end
      end

      assign zb.zo_vld = ovld_q;
      assign zb.zo_lck = olck_q;
      assign zb.zo_bus = obus_q;
      assign zb.zo_id  = oid_q;
    end
  endgenerate

endmodule

// File: tb/tb_zbus_arbiter.sv
// Bench for zbus_arbiter: REG=0 and REG=1 instances share stimulus, checked against a transaction-level model.
module tb_zbus_arbiter;
  import zbus_pkg::*;

  localparam int BW  = 8;
  localparam int BN  = 4;
  localparam int BNL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              mode;
  logic [BN-1:0]     vld, lck;
  logic [BW-1:0]     bus [BN];
  logic              zo_ack;
  int                prio_arr [BN];
  logic [BNL*BN-1:0] prio_vec;
  logic [BW*BN-1:0]  bus_vec;

  int errors = 0;
  int checks = 0;

  always_comb begin
    prio_vec = '0;
    bus_vec  = '0;
    for (int i = 0; i < BN; i++) begin
      prio_vec[i*BNL +: BNL] = BNL'(prio_arr[i]);
      bus_vec[i*BW +: BW]    = bus[i];
    end
  end

  zbus_arbiter_if #(.BW(BW), .BN(BN)) if0 ();
  zbus_arbiter_if #(.BW(BW), .BN(BN)) if1 ();

  assign if0.zi_vld = vld;
  assign if0.zi_lck = lck;
  assign if0.zi_bus = bus_vec;
  assign if0.zo_ack = zo_ack;
  assign if1.zi_vld = vld;
  assign if1.zi_lck = lck;
  assign if1.zi_bus = bus_vec;
  assign if1.zo_ack = zo_ack;

  zbus_arbiter #(.BW(BW), .BN(BN), .REG(0)) dut0 (
    .clk(clk), .rst(rst), .mode_i(mode), .prio_i(prio_vec), .zb(if0)
  );
  zbus_arbiter #(.BW(BW), .BN(BN), .REG(1)) dut1 (
    .clk(clk), .rst(rst), .mode_i(mode), .prio_i(prio_vec), .zb(if1)
  );

  typedef struct {
    int            g;
    int            nown;
    bit            done;
    logic [BN-1:0] ack;
    logic          vld;
    logic          lck;
    logic [BW-1:0] bus;
  } pred_t;

  typedef struct packed {
    logic           lck;
    logic [BW-1:0]  bus;
    logic [BNL-1:0] id;
  } beat_t;

  // Model state: owner (-1 = none), round-robin pointer, and accepted-but-undelivered beats of REG=1.
  int    own0 = -1, rr0 = BN - 1;
  int    own1 = -1, rr1 = BN - 1;
  beat_t q1[$];

  function automatic pred_t predict(input int own, input int rr, input bit regd, input bit full);
    pred_t p;
    bit    a;
    p.g = own; p.nown = -1; p.done = 1'b0; p.ack = '0;
    p.vld = 1'b0; p.lck = 1'b0; p.bus = '0;
    if (p.g < 0) begin
      if (mode == ZBUS_MODE_FIXED) begin
        for (int k = 0; k < BN; k++)
          if (p.g < 0 && vld[prio_arr[k]]) p.g = prio_arr[k];
      end else begin
        for (int o = 1; o <= BN; o++)
          if (p.g < 0 && vld[(rr + o) % BN]) p.g = (rr + o) % BN;
      end
    end
    if (p.g >= 0) begin
      a = regd ? (!full || zo_ack) : zo_ack;
      p.ack[p.g] = a;
      p.vld  = vld[p.g];
      p.lck  = lck[p.g];
      p.bus  = bus[p.g];
      p.done = p.vld && a;
      if ((p.vld && !p.done) || p.lck) p.nown = p.g;
    end
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare at negedge, advance the model at posedge. eid=-2 skips the directed REG=0 checks.
  task automatic cycle(input int eid, input logic [BN-1:0] eack);
    pred_t p0, p1;
    beat_t f;
    @(negedge clk);
    p0 = predict(own0, rr0, 1'b0, 1'b0);
    p1 = predict(own1, rr1, 1'b1, q1.size() != 0);
    check("r0_vld", if0.zo_vld, p0.vld);
    check("r0_lck", if0.zo_lck, p0.lck);
    check("r0_bus", if0.zo_bus, p0.bus);
    check("r0_id",  if0.zo_id,  (p0.g < 0) ? 0 : p0.g);
    check("r0_ack", if0.zi_ack, p0.ack);
    f = (q1.size() != 0) ? q1[0] : '0;
    check("r1_ack",  if1.zi_ack, p1.ack);
    check("r1_vld",  if1.zo_vld, q1.size() != 0);
    check("r1_beat", {if1.zo_lck, if1.zo_bus, if1.zo_id}, f);
    if (eid != -2) begin
      check("dir_id",  if0.zo_id,  (eid < 0) ? 0 : eid);
      check("dir_vld", if0.zo_vld, eid >= 0);
      check("dir_ack", if0.zi_ack, eack);
    end
    @(posedge clk);
    if (rst) begin
      own0 = -1; rr0 = BN - 1;
      own1 = -1; rr1 = BN - 1;
      q1.delete();
    end else begin
      own0 = p0.nown;
      if (p0.done) rr0 = p0.g;
      own1 = p1.nown;
      if (p1.done) rr1 = p1.g;
      if (q1.size() != 0 && zo_ack) void'(q1.pop_front());
      if (p1.done) q1.push_back({p1.lck, p1.bus, BNL'(p1.g)});
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; mode = ZBUS_MODE_FIXED; vld = '0; lck = '0; zo_ack = 1'b0;
    for (int i = 0; i < BN; i++) begin
      prio_arr[i] = i;
      bus[i]      = BW'(8'h10 + i);
    end
    cycle(-1, '0);
    cycle(-1, '0);
    rst = 1'b0;

    // Fixed priority {0,1,2,3}: port 1 beats port 3, then port 3 alone
    vld = 4'b1010; zo_ack = 1'b1;
    cycle(1, 4'b0010);
    vld = 4'b1000;
    cycle(3, 4'b1000);
    vld = '0;
    cycle(-1, '0);

    // Round robin, everyone requesting: 0,1,2,3,0
    mode = ZBUS_MODE_RR; vld = 4'b1111;
    for (int i = 0; i < 5; i++) cycle(i % 4, BN'(1 << (i % 4)));
    vld = '0; mode = ZBUS_MODE_FIXED;
    cycle(-1, '0);

    // Lock: port 2 keeps the bus against higher-priority port 0
    vld = 4'b0100; lck = 4'b0100;
    cycle(2, 4'b0100);
    vld = 4'b0101;
    cycle(2, 4'b0100);
    cycle(2, 4'b0100);
    lck = '0;
    cycle(2, 4'b0100);
    cycle(0, 4'b0001);
    vld = '0;
    cycle(-1, '0);

    // Backpressure: port 1 stalled 5 cycles, port 0 waiting, then one completing beat
    zo_ack = 1'b0; vld = 4'b0010; bus[1] = 8'h5A;
    cycle(1, '0);
    vld = 4'b0011;
    for (int i = 0; i < 4; i++) cycle(1, '0);
    zo_ack = 1'b1;
    cycle(1, 4'b0010);
    vld = 4'b0001;
    cycle(0, 4'b0001);
    vld = '0;
    cycle(-1, '0);

    // Random streaming with random backpressure, lock, mode and priority list
    for (int n = 0; n < 400; n++) begin
      vld    = BN'($urandom);
      lck    = '0;
      for (int i = 0; i < BN; i++) begin
        lck[i] = ($urandom_range(0, 4) == 0);
        bus[i] = BW'($urandom);
      end
      zo_ack = ($urandom_range(0, 3) != 0);
      if (n % 50 == 0) begin
        mode = 1'($urandom);
        for (int k = 0; k < BN; k++) prio_arr[k] = $urandom_range(0, BN - 1);
      end
      cycle(-2, '0);
    end

    // Reset while port 1 owns with a pending beat
    vld = '0; lck = '0; zo_ack = 1'b1;
    cycle(-2, '0);
    cycle(-2, '0);
    mode = ZBUS_MODE_FIXED;
    for (int k = 0; k < BN; k++) prio_arr[k] = k;
    vld = 4'b0010; zo_ack = 1'b0;
    cycle(1, '0);
    rst = 1'b1;
    cycle(1, '0);
    rst = 1'b0; vld = '0;
    cycle(-1, '0);
    mode = ZBUS_MODE_RR; vld = 4'b1111; zo_ack = 1'b1;
    cycle(0, 4'b0001);
    cycle(1, 4'b0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
